mem_access_ctrl: RTL

Sequencing controller for the MEM-stage data port of the RV64 core. It accepts one load or store per pipeline command and drives a valid/ready request channel to data memory. It waits for the load response, then selects, sign- or zero-extends and registers the result for writeback. It also stalls the pipeline while a transaction is outstanding, detects misalignment and handles flush.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/load_extend.sv | 25 ++
 rtl/mem_access_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared width codes, controller states and alignment/mask helpers
package mem_pkg;
  localparam logic [2:0] MW_NONE = 3'd0;
  localparam logic [2:0] MW_D    = 3'd1;
  localparam logic [2:0] MW_W    = 3'd2;
  localparam logic [2:0] MW_H    = 3'd3;
  localparam logic [2:0] MW_B    = 3'd4;
  localparam logic [2:0] MW_WU   = 3'd5;
  localparam logic [2:0] MW_HU   = 3'd6;
  localparam logic [2:0] MW_BU   = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

  function automatic logic [7:0] store_mask(input logic [2:0] width, input logic [2:0] a);
    return width == MW_D ? 8'hFF :
           (width == MW_W || width == MW_WU) ? 8'h0F << a :
           (width == MW_H || width == MW_HU) ? 8'h03 << a :
           (width == MW_B || width == MW_BU) ? 8'h01 << a : 8'h00;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] width, input logic [2:0] addr);
    return width == MW_D ? addr != 3'd0 :
           (width == MW_W || width == MW_WU) ? addr[1:0] != 2'd0 :
           (width == MW_H || width == MW_HU) ? addr[0] : 1'b0;
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the load lane from a doubleword and sign/zero-extends it
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  width,
  input  logic [2:0]  a,
  output logic [63:0] data
);
  logic [31:0] w;
  logic [15:0] h;
  logic [7:0]  b;
  assign w = rdata[{a[2], 5'b0} +: 32];
  assign h = rdata[{a[2:1], 4'b0} +: 16];
  assign b = rdata[{a, 3'b0} +: 8];
  always_comb begin
    data = width == MW_D  ? rdata :
           width == MW_W  ? {{32{w[31]}}, w} :
           width == MW_WU ? {32'd0, w} :
           width == MW_H  ? {{48{h[15]}}, h} :
           width == MW_HU ? {48'd0, h} :
           width == MW_B  ? {{56{b[7]}}, b} :
           width == MW_BU ? {56'd0, b} : 64'd0;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer driving a valid/ready data port
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic        cmd_load,
  input  logic        cmd_store,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [63:0] alu_res,
  input  logic [2:0]  memdata_width,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [7:0]  mem_req_wmask,
  output logic [63:0] mem_req_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic [63:0] rd_data,
  output logic        misalign
);
  state_t      state, nxt;
  logic [63:0] addr_q, wdata_q, rd_q, ext;
  logic [2:0]  width_q;
  logic        load_q, mis_q, is_mem, accept;

  assign is_mem = cmd_valid & (cmd_load | cmd_store) & (memdata_width != MW_NONE);
  assign accept = state == S_IDLE & is_mem & ~flush;

  load_extend u_ext (.rdata(mem_rdata), .width(width_q), .a(addr_q[2:0]), .data(ext));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= MW_NONE;
      load_q  <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        width_q <= memdata_width;
        load_q  <= cmd_load;
        mis_q   <= is_misaligned(memdata_width, addr[2:0]);
        rd_q    <= '0;
      end else if (state == S_WAIT && mem_rvalid) begin
        rd_q <= ext;
      end
    end
  end

  always_comb begin
    nxt = state == S_IDLE  ? (accept ? (is_misaligned(memdata_width, addr[2:0]) ? S_DONE : S_REQ) : S_IDLE) :
          state == S_REQ   ? (mem_req_ready ? (load_q ? S_WAIT : S_DONE) : flush ? S_IDLE : S_REQ) :
          state == S_WAIT  ? (mem_rvalid ? (flush ? S_IDLE : S_DONE) : flush ? S_DRAIN : S_WAIT) :
          state == S_DRAIN ? (mem_rvalid ? S_IDLE : S_DRAIN) : S_IDLE;
    mem_req_valid = state == S_REQ;
    mem_req_addr  = {addr_q[63:3], 3'b000};
    mem_req_wen   = state == S_REQ & ~load_q;
    mem_req_wmask = load_q ? 8'h00 : store_mask(width_q, addr_q[2:0]);
    mem_req_wdata = wdata_q << {addr_q[2:0], 3'b000};
    stall         = (is_mem & state != S_DONE) | state == S_DRAIN;
    done          = state == S_DONE & ~flush;
    misalign      = state == S_DONE & ~flush & mis_q;
    rd_data       = (state == S_IDLE & cmd_valid & ~is_mem) ? alu_res : rd_q;
  end
endmodule
